// File: rtl/source_product_description_info_frame_receiver_pkg.sv
// Shared constants and types for the SPD InfoFrame receiver.
// Byte indices count every byte of a packet: 0..2 are HB0..HB2 and
// 3..30 are PB0..PB27.
package spd_info_frame_pkg;

  localparam logic [7:0]  SPD_TYPE     = 8'h83;
  localparam logic [7:0]  SPD_VERSION  = 8'h01;
  localparam logic [4:0]  SPD_LENGTH   = 5'd25;
  localparam int unsigned PACKET_BYTES = 31;

  localparam logic [4:0] IDX_HB1       = 5'd1;
  localparam logic [4:0] IDX_PB1       = 5'd4;
  localparam logic [4:0] IDX_PB9       = 5'd12;
  localparam logic [4:0] IDX_PB25      = 5'd28;
  localparam logic [4:0] IDX_LAST_CSUM = 5'd28;
  localparam logic [4:0] IDX_LAST      = 5'(PACKET_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_SKIP,
    ST_CHECK
  } spd_state_e;

endpackage

// File: rtl/source_product_description_info_frame_receiver_if.sv
// Packet byte stream from the data-island decoder.
//   packet_start : marks the current byte as HB0 (only with byte_valid)
//   byte_valid   : byte_data carries a byte this cycle
//   byte_data    : HB0, HB1, HB2, PB0..PB27
// master drives the stream, slave consumes it.
interface source_product_description_info_frame_receiver_if;
  logic       packet_start;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (output packet_start, byte_valid, byte_data);
  modport slave  (input  packet_start, byte_valid, byte_data);
endinterface

// File: rtl/source_product_description_info_frame_receiver_checksum.sv
// info_frame_checksum_accumulator: 8-bit modulo byte sum for InfoFrame
// checksum validation; usable by any InfoFrame receiver.
//   clk_i, rst_n_i : clock, async active-low reset
//   clear_i        : restart the sum (the byte is loaded if add_i is also set)
//   add_i          : accumulate byte_i
//   byte_i         : byte to accumulate
//   sum_o          : running sum
//   is_zero_o      : running sum equals zero
module info_frame_checksum_accumulator (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o,
  output logic       is_zero_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i)    sum_d = add_i ? byte_i : '0;
    else if (add_i) sum_d = sum_q + byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign sum_o     = sum_q;
  assign is_zero_o = (sum_q == '0);

endmodule

// File: rtl/source_product_description_info_frame_receiver.sv
// SPD InfoFrame (type 0x83) receiver. Validates header and checksum of
// each packet and publishes vendor name, product description and source
// device information from the last good frame.
//   clk_pixel, reset_n        : pixel clock, async active-low reset
//   pkt                       : packet byte stream (slave modport)
//   vendor_name               : PB1 at [63:56] .. PB8 at [7:0]
//   product_description       : PB9 at [127:120] .. PB24 at [7:0]
//   source_device_information : PB25
//   spd_valid                 : at least one good frame held
//   spd_update                : 1-cycle pulse when outputs refresh
//   packet_error              : 1-cycle pulse on a rejected SPD packet
// Optional macro SPD_RX_STATS_EN adds saturating good_count/error_count.
module source_product_description_info_frame_receiver
  import spd_info_frame_pkg::*;
#(
  parameter bit CHECK_VERSION = 1'b1,
  parameter bit HOLD_ON_ERROR = 1'b1
) (
  input  logic                                              clk_pixel,
  input  logic                                              reset_n,
  source_product_description_info_frame_receiver_if.slave  pkt,
  output logic [63:0]                                       vendor_name,
  output logic [127:0]                                      product_description,
  output logic [7:0]                                        source_device_information,
  output logic                                              spd_valid,
  output logic                                              spd_update,
  output logic                                              packet_error
`ifdef SPD_RX_STATS_EN
  ,
  output logic [15:0]                                       good_count,
  output logic [15:0]                                       error_count
`endif
);

  spd_state_e   state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic         mism_q, mism_d;
  logic [63:0]  vend_sh_q, vend_sh_d;
  logic [127:0] desc_sh_q, desc_sh_d;
  logic [7:0]   sdi_sh_q, sdi_sh_d;
  logic         cs_clear, cs_add, cs_zero;
  logic [7:0]   cs_sum;
  logic         publish, reject;
  logic         unused_cs_sum;

  info_frame_checksum_accumulator u_csum (
    .clk_i     (clk_pixel),
    .rst_n_i   (reset_n),
    .clear_i   (cs_clear),
    .add_i     (cs_add),
    .byte_i    (pkt.byte_data),
    .sum_o     (cs_sum),
    .is_zero_o (cs_zero)
  );

  assign unused_cs_sum = ^cs_sum;

  // Verdict is taken on the PB27 handshake: PB26/PB27 are outside the
  // checksum, so the sum is already final. Outputs then change on the same
  // edge that enters CHECK, making spd_update coincide with the new data.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mism_d    = mism_q;
    vend_sh_d = vend_sh_q;
    desc_sh_d = desc_sh_q;
    sdi_sh_d  = sdi_sh_q;
    cs_clear  = 1'b0;
    cs_add    = 1'b0;
    publish   = 1'b0;
    reject    = 1'b0;

    if (pkt.byte_valid && pkt.packet_start) begin
      // A new HB0 restarts reception from any state; a partial packet is
      // dropped without error.
      if (pkt.byte_data == SPD_TYPE) begin
        state_d  = ST_HEADER;
        idx_d    = 5'd1;
        mism_d   = 1'b0;
        cs_clear = 1'b1;
        cs_add   = 1'b1;
      end else begin
        state_d = ST_SKIP;
        idx_d   = '0;
      end
    end else begin
      unique case (state_q)
        ST_HEADER: begin
          if (pkt.byte_valid) begin
            cs_add = 1'b1;
            idx_d  = idx_q + 5'd1;
            if (idx_q == IDX_HB1) begin
              if (CHECK_VERSION && (pkt.byte_data != SPD_VERSION)) mism_d = 1'b1;
            end else begin
              if (pkt.byte_data[4:0] != SPD_LENGTH) mism_d = 1'b1;
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (pkt.byte_valid) begin
            cs_add = (idx_q <= IDX_LAST_CSUM);
            if ((idx_q >= IDX_PB1) && (idx_q < IDX_PB9))
              vend_sh_d = {vend_sh_q[55:0], pkt.byte_data};
            if ((idx_q >= IDX_PB9) && (idx_q < IDX_PB25))
              desc_sh_d = {desc_sh_q[119:0], pkt.byte_data};
            if (idx_q == IDX_PB25)
              sdi_sh_d = pkt.byte_data;
            if (idx_q == IDX_LAST) begin
              state_d = ST_CHECK;
              idx_d   = '0;
              if (cs_zero && !mism_q) publish = 1'b1;
              else                    reject  = 1'b1;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
        ST_CHECK: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mism_q    <= 1'b0;
      vend_sh_q <= '0;
      desc_sh_q <= '0;
      sdi_sh_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mism_q    <= mism_d;
      vend_sh_q <= vend_sh_d;
      desc_sh_q <= desc_sh_d;
      sdi_sh_q  <= sdi_sh_d;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      vendor_name               <= '0;
      product_description       <= '0;
      source_device_information <= '0;
      spd_valid                 <= 1'b0;
      spd_update                <= 1'b0;
      packet_error              <= 1'b0;
    end else begin
      spd_update   <= publish;
      packet_error <= reject;
      if (publish) begin
        vendor_name               <= vend_sh_q;
        product_description       <= desc_sh_q;
        source_device_information <= sdi_sh_q;
        spd_valid                 <= 1'b1;
      end else if (reject && !HOLD_ON_ERROR) begin
        spd_valid <= 1'b0;
      end
    end
  end

`ifdef SPD_RX_STATS_EN
  logic [15:0] good_q, err_q;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      good_q <= '0;
      err_q  <= '0;
    end else begin
      if (publish && (good_q != '1)) good_q <= good_q + 16'd1;
      if (reject  && (err_q  != '1)) err_q  <= err_q + 16'd1;
    end
  end

  assign good_count  = good_q;
  assign error_count = err_q;
`endif

endmodule
